// File: rtl/pc_bus_pkg.sv
// Shared PC bus definitions: arbiter state encoding and 8088 status codes
// common to the DMA arbiter and the 8288 bench.
package pc_bus_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_IDLE = 3'd1,
      HANDOFF   = 3'd2,
      GRANT     = 3'd3,
      RELEASE   = 3'd4
   } arb_state_t;

   localparam logic [2:0] S_PASSIVE = 3'b111;
   localparam logic [2:0] S_HALT    = 3'b011;

   // Halt leaves the bus as free as a passive status does.
   function automatic logic is_passive(input logic [2:0] s);
      return (s == S_PASSIVE) || (s == S_HALT);
   endfunction

endpackage

// File: rtl/bus_idle_detect.sv
// Declares the CPU bus idle once enough consecutive passive/halt status
// samples have been seen and the CPU is not holding LOCK.
module bus_idle_detect
   import pc_bus_pkg::*;
#(
   parameter int PASSIVE_MIN = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] s_n,
   input  logic       lock_n,
   output logic       bus_idle
);

   localparam logic [2:0] MIN_CNT = 3'(PASSIVE_MIN);

   logic [2:0] pass_cnt_q;
   logic [2:0] pass_cnt_d;

   always_comb begin
      pass_cnt_d = 3'd0;
      if (is_passive(s_n)) begin
         pass_cnt_d = (pass_cnt_q == 3'd7) ? 3'd7 : pass_cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pass_cnt_q <= 3'd0;
      end else begin
         pass_cnt_q <= pass_cnt_d;
      end
   end

   assign bus_idle = (pass_cnt_q >= MIN_CNT) && lock_n;

endmodule

// File: rtl/dma_bus_arbiter.sv
// Hands the system bus between the 8088/8288 and the 8237 DMA controller,
// only between CPU bus cycles, with registered Moore outputs.
module dma_bus_arbiter
   import pc_bus_pkg::*;
#(
   parameter int PASSIVE_MIN = 2,
   parameter int TURNAROUND  = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] s_n,
   input  logic       lock_n,
   input  logic       hrq,
   output logic       holda,
   output logic       dma_aen,
   output logic       aen_n,
   output logic       cpu_rdy
);

   localparam logic [2:0] TA_LOAD = 3'(TURNAROUND - 1);

   logic       bus_idle;
   arb_state_t state_q, state_d;
   logic [2:0] ta_cnt_q, ta_cnt_d;
   logic       holda_q, holda_d;
   logic       dma_aen_q, dma_aen_d;
   logic       aen_n_q, aen_n_d;
   logic       cpu_rdy_q, cpu_rdy_d;

   bus_idle_detect #(
      .PASSIVE_MIN(PASSIVE_MIN)
   ) u_idle (
      .clk     (clk),
      .reset_n (reset_n),
      .s_n     (s_n),
      .lock_n  (lock_n),
      .bus_idle(bus_idle)
   );

   always_comb begin
      state_d  = state_q;
      ta_cnt_d = ta_cnt_q;
      case (state_q)
         IDLE, WAIT_IDLE: begin
            if (!hrq) begin
               state_d = IDLE;
            end else if (bus_idle) begin
               state_d  = HANDOFF;
               ta_cnt_d = TA_LOAD;
            end else begin
               state_d = WAIT_IDLE;
            end
         end
         // A dropped request beats turnaround expiry so a one-cycle hrq never pulses holda.
         HANDOFF: begin
            if (!hrq) begin
               state_d  = RELEASE;
               ta_cnt_d = TA_LOAD;
            end else if (ta_cnt_q == 3'd0) begin
               state_d = GRANT;
            end else begin
               ta_cnt_d = ta_cnt_q - 3'd1;
            end
         end
         GRANT: begin
            if (!hrq) begin
               state_d  = RELEASE;
               ta_cnt_d = TA_LOAD;
            end
         end
         RELEASE: begin
            if (ta_cnt_q == 3'd0) begin
               state_d = IDLE;
            end else begin
               ta_cnt_d = ta_cnt_q - 3'd1;
            end
         end
         default: begin
            state_d  = IDLE;
            ta_cnt_d = 3'd0;
         end
      endcase

      holda_d   = (state_d == GRANT);
      dma_aen_d = (state_d == GRANT);
      aen_n_d   = (state_d == HANDOFF) || (state_d == GRANT) || (state_d == RELEASE);
      cpu_rdy_d = !aen_n_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ta_cnt_q  <= 3'd0;
         holda_q   <= 1'b0;
         dma_aen_q <= 1'b0;
         aen_n_q   <= 1'b0;
         cpu_rdy_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         ta_cnt_q  <= ta_cnt_d;
         holda_q   <= holda_d;
         dma_aen_q <= dma_aen_d;
         aen_n_q   <= aen_n_d;
         cpu_rdy_q <= cpu_rdy_d;
      end
   end

   assign holda   = holda_q;
   assign dma_aen = dma_aen_q;
   assign aen_n   = aen_n_q;
   assign cpu_rdy = cpu_rdy_q;

endmodule
